// File: rtl/vfpu_mul_lanes.sv
// Multi-lane pipelined FP multiplier (S1 unpack, S2 multiply, S3 normalise/round/pack); optional VFPU_MUL_STICKY_FLAGS_EN.
// Latency: 3 cycles from input handshake to out_valid_o; 1 vector/cycle sustained.
// Backpressure: each stage loads when empty or drained; in_ready_o follows out_ready_i combinationally.
module vfpu_mul_lanes #(
    parameter int NB_LANES   = 4,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    localparam int FP_W      = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NB_LANES*FP_W-1:0] in_a_i,
    input  logic [NB_LANES*FP_W-1:0] in_b_i,
    input  logic [1:0]               in_rnd_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NB_LANES*FP_W-1:0] out_res_o,
    output logic [NB_LANES*6-1:0]    out_flags_o
`ifdef VFPU_MUL_STICKY_FLAGS_EN
    ,
    output logic [5:0]               sticky_flags_o
`endif
);

    localparam int EW = EXP_WIDTH;
    localparam int MW = MANT_WIDTH;
    localparam int PW = 2 * MW + 2;
    localparam int XW = EW + 2;
    localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EW - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_OVF  = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic [EW-1:0]        EXP_ONES = '1;
    localparam logic [EW-1:0]        EXP_MAXF = {{(EW - 1){1'b1}}, 1'b0};
    localparam logic [MW-1:0]        QNAN_M   = MW'(1) | (MW'(1) << (MW - 1));

    typedef enum logic [1:0] {CL_NORM, CL_ZERO, CL_INF, CL_NAN} cls_e;

    logic       r_s1_vld, r_s2_vld, r_s3_vld;
    logic [1:0] r_s1_rnd, r_s2_rnd;
    logic       w_s1_en, w_s2_en, w_s3_en;
    logic       w_s1_ld, w_s2_ld, w_s3_ld;

    assign w_s3_en     = ~r_s3_vld | out_ready_i;
    assign w_s2_en     = ~r_s2_vld | w_s3_en;
    assign w_s1_en     = ~r_s1_vld | w_s2_en;
    assign in_ready_o  = w_s1_en & ~clear_i;
    assign w_s1_ld     = in_valid_i & in_ready_o;
    assign w_s2_ld     = w_s2_en & r_s1_vld & ~clear_i;
    assign w_s3_ld     = w_s3_en & r_s2_vld & ~clear_i;
    assign out_valid_o = r_s3_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
        end else if (clear_i) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
        end else begin
            if (w_s1_en) r_s1_vld <= in_valid_i;
            if (w_s2_en) r_s2_vld <= r_s1_vld;
            if (w_s3_en) r_s3_vld <= r_s2_vld;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_rnd <= 2'b00;
            r_s2_rnd <= 2'b00;
        end else begin
            if (w_s1_ld) r_s1_rnd <= in_rnd_i;
            if (w_s2_ld) r_s2_rnd <= r_s1_rnd;
        end
    end

    for (genvar g = 0; g < NB_LANES; g++) begin : g_lane
        logic [FP_W-1:0]       w_a, w_b;
        logic [EW-1:0]         w_ea, w_eb;
        logic                  w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
        cls_e                  w_cls;
        logic                  r_s1_sign, r_s2_sign;
        logic signed [XW-1:0]  r_s1_exp, r_s2_exp;
        logic [MW:0]           r_s1_ma, r_s1_mb;
        cls_e                  r_s1_cls, r_s2_cls;
        logic [PW-1:0]         r_s2_prod;
        logic [FP_W-1:0]       r_res;
        logic [5:0]            r_flags;
        logic [PW-1:0]         w_pn;
        logic [MW:0]           w_mant;
        logic [MW+1:0]         w_mr;
        logic [MW-1:0]         w_frac;
        logic signed [XW-1:0]  w_e2;
        logic                  w_guard, w_sticky, w_inexact, w_inc, w_to_inf;
        logic [FP_W-1:0]       w_res;
        logic [5:0]            w_flags;

        assign w_a      = in_a_i[g*FP_W +: FP_W];
        assign w_b      = in_b_i[g*FP_W +: FP_W];
        assign w_ea     = w_a[FP_W-2 -: EW];
        assign w_eb     = w_b[FP_W-2 -: EW];
        assign w_a_zero = (w_ea == '0);
        assign w_b_zero = (w_eb == '0);
        assign w_a_inf  = (w_ea == EXP_ONES) && (w_a[MW-1:0] == '0);
        assign w_b_inf  = (w_eb == EXP_ONES) && (w_b[MW-1:0] == '0);
        assign w_a_nan  = (w_ea == EXP_ONES) && (w_a[MW-1:0] != '0);
        assign w_b_nan  = (w_eb == EXP_ONES) && (w_b[MW-1:0] != '0);

        // Denormals land in CL_ZERO, which is what flushes them.
        always_comb begin
            w_cls = CL_NORM;
            if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
                w_cls = CL_NAN;
            else if (w_a_inf || w_b_inf)
                w_cls = CL_INF;
            else if (w_a_zero || w_b_zero)
                w_cls = CL_ZERO;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_s1_sign <= 1'b0;
                r_s1_exp  <= '0;
                r_s1_ma   <= '0;
                r_s1_mb   <= '0;
                r_s1_cls  <= CL_NORM;
                r_s2_sign <= 1'b0;
                r_s2_exp  <= '0;
                r_s2_prod <= '0;
                r_s2_cls  <= CL_NORM;
                r_res     <= '0;
                r_flags   <= '0;
            end else begin
                if (w_s1_ld) begin
                    r_s1_sign <= w_a[FP_W-1] ^ w_b[FP_W-1];
                    r_s1_exp  <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;
                    r_s1_ma   <= {1'b1, w_a[MW-1:0]};
                    r_s1_mb   <= {1'b1, w_b[MW-1:0]};
                    r_s1_cls  <= w_cls;
                end
                if (w_s2_ld) begin
                    r_s2_sign <= r_s1_sign;
                    r_s2_exp  <= r_s1_exp;
                    r_s2_prod <= PW'(r_s1_ma) * PW'(r_s1_mb);
                    r_s2_cls  <= r_s1_cls;
                end
                if (w_s3_ld) begin
                    r_res   <= w_res;
                    r_flags <= w_flags;
                end
            end
        end

        // Left-align the product so guard/sticky positions are fixed; MSB=1 means value in [2,4).
        always_comb begin
            w_pn      = r_s2_prod[PW-1] ? r_s2_prod : (r_s2_prod << 1);
            w_mant    = w_pn[PW-1 -: MW+1];
            w_guard   = w_pn[MW];
            w_sticky  = |w_pn[MW-1:0];
            w_inexact = w_guard | w_sticky;
            case (r_s2_rnd)
                2'b00:   w_inc = 1'b0;
                2'b01:   w_inc = w_guard & (w_sticky | w_mant[0]);
                2'b10:   w_inc = ~r_s2_sign & w_inexact;
                default: w_inc = r_s2_sign & w_inexact;
            endcase
            w_mr     = {1'b0, w_mant} + (MW+2)'(w_inc);
            w_e2     = r_s2_exp + $signed({{(XW-1){1'b0}}, r_s2_prod[PW-1]})
                                + $signed({{(XW-1){1'b0}}, w_mr[MW+1]});
            w_frac   = w_mr[MW+1] ? w_mr[MW:1] : w_mr[MW-1:0];
            w_to_inf = (r_s2_rnd == 2'b01) || (r_s2_rnd == 2'b10 && !r_s2_sign)
                    || (r_s2_rnd == 2'b11 && r_s2_sign);
            w_res    = {r_s2_sign, w_e2[EW-1:0], w_frac};
            w_flags  = {2'b00, w_inexact, 3'b000};
            case (r_s2_cls)
                CL_NAN: begin
                    w_res   = {1'b1, EXP_ONES, QNAN_M};
                    w_flags = 6'b000000;
                end
                CL_INF: begin
                    w_res   = {r_s2_sign, EXP_ONES, {MW{1'b0}}};
                    w_flags = 6'b000000;
                end
                CL_ZERO: begin
                    w_res   = {r_s2_sign, {(FP_W-1){1'b0}}};
                    w_flags = 6'b000100;
                end
                default: begin
                    if (w_e2 >= EXP_OVF) begin
                        w_res   = w_to_inf ? {r_s2_sign, EXP_ONES, {MW{1'b0}}}
                                           : {r_s2_sign, EXP_MAXF, {MW{1'b1}}};
                        w_flags = 6'b011000;
                    end else if (w_e2 <= EXP_ZERO) begin
                        w_res   = {r_s2_sign, {(FP_W-1){1'b0}}};
                        w_flags = 6'b101100;
                    end
                end
            endcase
            if (w_res[FP_W-2:0] == {EXP_ONES, {MW{1'b0}}}) begin
                w_flags[1] = ~w_res[FP_W-1];
                w_flags[0] = w_res[FP_W-1];
            end
        end

        assign out_res_o[g*FP_W +: FP_W] = r_res;
        assign out_flags_o[g*6 +: 6]     = r_flags;
    end

`ifdef VFPU_MUL_STICKY_FLAGS_EN
    logic [5:0] r_sticky;
    logic [5:0] w_lane_or;

    always_comb begin
        w_lane_or = '0;
        for (int k = 0; k < NB_LANES; k++) w_lane_or = w_lane_or | out_flags_o[k*6 +: 6];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                       r_sticky <= '0;
        else if (clear_i)                  r_sticky <= '0;
        else if (r_s3_vld && out_ready_i)  r_sticky <= r_sticky | w_lane_or;
    end

    assign sticky_flags_o = r_sticky;
`endif

endmodule

// File: tb/tb_vfpu_mul_lanes.sv
// Bench for vfpu_mul_lanes at default single precision: directed table, streams vs. integer reference model.
module tb_vfpu_mul_lanes;
    localparam int NL = 4;
    localparam int NV = 22;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b1;
    logic           clear_i = 1'b0;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [NL*32-1:0] in_a_i = '0;
    logic [NL*32-1:0] in_b_i = '0;
    logic [1:0]     in_rnd_i = 2'b01;
    logic           out_valid_o;
    logic           out_ready_i = 1'b1;
    logic [NL*32-1:0] out_res_o;
    logic [NL*6-1:0]  out_flags_o;
`ifdef VFPU_MUL_STICKY_FLAGS_EN
    logic [5:0]     sticky_flags_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [5:0] tb_sticky = '0;

    always #5 clk_i = ~clk_i;

    vfpu_mul_lanes #(.NB_LANES(NL), .EXP_WIDTH(8), .MANT_WIDTH(23)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .in_rnd_i(in_rnd_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_res_o(out_res_o), .out_flags_o(out_flags_o)
`ifdef VFPU_MUL_STICKY_FLAGS_EN
        , .sticky_flags_o(sticky_flags_o)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rnd;
        logic [31:0] res;
        logic [5:0]  flg;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer product, rounding decided from quotient/remainder.
    function automatic logic [37:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd);
        logic [7:0]  ea, eb;
        logic        za, zb, ia, ib, na, nb, s, inexact, up, to_inf;
        longint unsigned p, q, rem, half;
        int          e, sh;
        logic [31:0] r;
        logic [5:0]  f;
        ea = a[30:23]; eb = b[30:23];
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 8'hFF) && (a[22:0] == 0); ib = (eb == 8'hFF) && (b[22:0] == 0);
        na = (ea == 8'hFF) && (a[22:0] != 0); nb = (eb == 8'hFF) && (b[22:0] != 0);
        s = a[31] ^ b[31];
        f = 6'b0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r = 32'hFFC00001;
        end else if (ia || ib) begin
            r = {s, 8'hFF, 23'h0};
        end else if (za || zb) begin
            r = {s, 31'h0};
            f = 6'b000100;
        end else begin
            p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
            e  = int'(ea) + int'(eb) - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            inexact = (rem != 0);
            case (rnd)
                2'b00:   up = 1'b0;
                2'b01:   up = (rem > half) || (rem == half && q[0]);
                2'b10:   up = !s && inexact;
                default: up = s && inexact;
            endcase
            q = q + longint'(up);
            if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
            to_inf = (rnd == 2'b01) || (rnd == 2'b10 && !s) || (rnd == 2'b11 && s);
            if (e >= 255) begin
                r = to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
                f = 6'b011000;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 6'b101100;
            end else begin
                r = {s, 8'(e), q[22:0]};
                f = {2'b00, inexact, 3'b000};
            end
        end
        if (r[30:0] == 31'h7F800000) begin
            f[1] = !r[31];
            f[0] = r[31];
        end
        return {r, f};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [22:0] m;
        int          sel;
        s   = 1'($urandom_range(0, 1));
        m   = 23'($urandom);
        sel = $urandom_range(0, 11);
        case (sel)
            0:       return {s, 31'h0};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 8'hFF, m | 23'h1};
            3:       return {s, 8'h00, m};
            4:       return {s, 8'($urandom_range(230, 254)), m};
            5:       return {s, 8'($urandom_range(1, 40)), m};
            6:       return {s, 8'd127, 23'h7FFFFF ^ 23'($urandom_range(0, 3))};
            default: return {s, 8'($urandom_range(90, 164)), m};
        endcase
    endfunction

    task automatic run_one(input logic [NL*32-1:0] a, input logic [NL*32-1:0] b, input logic [1:0] rnd,
                           output logic [NL*32-1:0] res, output logic [NL*6-1:0] flg, output int lat);
        @(negedge clk_i);
        in_a_i = a; in_b_i = b; in_rnd_i = rnd;
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i);
            #1 lat++;
        end
        res = out_res_o;
        flg = out_flags_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic stream(input int n, input bit bp, input string tag);
        logic [NL*32-1:0] va [], vb [];
        logic [1:0]       vr [];
        logic [NL*32-1:0] h_res;
        logic [NL*6-1:0]  h_flg;
        logic [37:0]      exp;
        bit hold, acc, last_acc;
        int sent, recv, stall_at, budget, dup;
        va = new[n]; vb = new[n]; vr = new[n];
        hold = 0; last_acc = 0; sent = 0; recv = 0; stall_at = -1; dup = 0;
        budget = n * 10 + 100;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < NL; k++) begin
                va[i][k*32 +: 32] = rand_fp();
                vb[i][k*32 +: 32] = rand_fp();
            end
            vr[i] = 2'($urandom_range(0, 3));
        end
        in_valid_i = 1'b0;
        for (int c = 0; c < budget && recv < n; c++) begin
            @(negedge clk_i);
            out_ready_i = bp ? (c >= 5) : ($urandom_range(0, 3) != 0);
            if (sent >= n) in_valid_i = 1'b0;
            else if (!in_valid_i || last_acc) in_valid_i = bp ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (sent < n) begin
                in_a_i = va[sent]; in_b_i = vb[sent]; in_rnd_i = vr[sent];
            end
            #1;
            if (hold) begin
                chk({tag, " hold"}, {out_valid_o, out_res_o, out_flags_o}, {1'b1, h_res, h_flg});
                hold = 0;
            end
            if (out_valid_o) begin
                if (out_ready_i) begin
                    for (int k = 0; k < NL; k++) begin
                        exp = ref_mul(va[recv][k*32 +: 32], vb[recv][k*32 +: 32], vr[recv]);
                        chk($sformatf("%s v%0d lane%0d", tag, recv, k),
                            {out_res_o[k*32 +: 32], out_flags_o[k*6 +: 6]}, exp);
                        tb_sticky = tb_sticky | exp[5:0];
                    end
                    recv++;
                end else begin
                    hold = 1; h_res = out_res_o; h_flg = out_flags_o;
                end
            end
            if (bp && in_valid_i && !in_ready_o && stall_at < 0) stall_at = sent;
            acc = in_valid_i && in_ready_o;
            @(posedge clk_i);
            last_acc = acc;
            if (acc) sent++;
        end
        chk({tag, " count"}, recv, n);
        if (bp) chk({tag, " stall_after"}, stall_at, 3);
        @(negedge clk_i);
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        repeat (6) begin
            #1 if (out_valid_o) dup++;
            @(negedge clk_i);
        end
        chk({tag, " no_dup"}, dup, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [NL*32-1:0] a, b, res;
        logic [NL*6-1:0]  fl;
        logic [37:0]      e;
        int lat, k, cnt;

        tbl[0]  = '{32'h3FC00000, 32'h40000000, 2'b01, 32'h40400000, 6'h00};
        tbl[1]  = '{32'h7F000000, 32'h7F000000, 2'b01, 32'h7F800000, 6'h1A};
        tbl[2]  = '{32'h7F000000, 32'h7F000000, 2'b00, 32'h7F7FFFFF, 6'h18};
        tbl[3]  = '{32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 6'h08};
        tbl[4]  = '{32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 6'h08};
        tbl[5]  = '{32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800003, 6'h08};
        tbl[6]  = '{32'h7F800000, 32'h00000000, 2'b01, 32'hFFC00001, 6'h00};
        tbl[7]  = '{32'h00800000, 32'h00800000, 2'b01, 32'h00000000, 6'h2C};
        tbl[8]  = '{32'hFF800000, 32'h3F800000, 2'b00, 32'hFF800000, 6'h01};
        tbl[9]  = '{32'h80000000, 32'h3F800000, 2'b01, 32'h80000000, 6'h04};
        tbl[10] = '{32'h7FC00000, 32'h3F800000, 2'b01, 32'hFFC00001, 6'h00};
        tbl[11] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 2'b10, 32'hFF7FFFFF, 6'h18};
        tbl[12] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 2'b11, 32'hFF800000, 6'h19};
        tbl[13] = '{32'h3FFFFFFE, 32'h3F800001, 2'b01, 32'h40000000, 6'h08};
        tbl[14] = '{32'h3FFFFFFE, 32'h3F800001, 2'b00, 32'h3FFFFFFF, 6'h08};
        tbl[15] = '{32'h7F000000, 32'h3FFFFFFF, 2'b00, 32'h7F7FFFFF, 6'h00};
        tbl[16] = '{32'h7F000000, 32'h40000000, 2'b11, 32'h7F7FFFFF, 6'h18};
        tbl[17] = '{32'h20000000, 32'h1F800000, 2'b01, 32'h00000000, 6'h2C};
        tbl[18] = '{32'h20000000, 32'h20000000, 2'b01, 32'h00800000, 6'h00};
        tbl[19] = '{32'h00400000, 32'h7F800000, 2'b01, 32'hFFC00001, 6'h00};
        tbl[20] = '{32'h00400000, 32'hBF800000, 2'b01, 32'h80000000, 6'h04};
        tbl[21] = '{32'h3F800000, 32'h3F800000, 2'b10, 32'h3F800000, 6'h00};

        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset out_valid", out_valid_o, 0);
        chk("reset out_res", out_res_o, 0);
        chk("reset out_flags", out_flags_o, 0);
        rst_ni = 1'b1;
        #1 chk("reset in_ready", in_ready_o, 1);
`ifdef VFPU_MUL_STICKY_FLAGS_EN
        chk("reset sticky", sticky_flags_o, 0);
`endif

        for (int i = 0; i < NV; i++) begin
            k = i % NL;
            a = {NL{32'h3F800000}};
            b = {NL{32'h3F800000}};
            a[k*32 +: 32] = tbl[i].a;
            b[k*32 +: 32] = tbl[i].b;
            run_one(a, b, tbl[i].rnd, res, fl, lat);
            chk($sformatf("vec%0d res", i), res[k*32 +: 32], tbl[i].res);
            chk($sformatf("vec%0d flags", i), fl[k*6 +: 6], tbl[i].flg);
            chk($sformatf("vec%0d latency", i), lat, 3);
            for (int j = 0; j < NL; j++) begin
                e = ref_mul(a[j*32 +: 32], b[j*32 +: 32], tbl[i].rnd);
                tb_sticky = tb_sticky | e[5:0];
            end
        end

        stream(6, 1'b1, "bp");
        stream(150, 1'b0, "rand");
`ifdef VFPU_MUL_STICKY_FLAGS_EN
        chk("sticky accum", sticky_flags_o, tb_sticky);
`endif

        // Three vectors in flight, then clear coinciding with an input offer and an output handshake.
        @(negedge clk_i);
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        in_a_i = {NL{32'h7F000000}}; in_b_i = {NL{32'h7F000000}}; in_rnd_i = 2'b01;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        clear_i = 1'b1; out_ready_i = 1'b1;
        #1 chk("clear in_ready", in_ready_o, 0);
        chk("clear full before", out_valid_o, 1);
        @(negedge clk_i);
        clear_i = 1'b0; in_valid_i = 1'b0;
        tb_sticky = '0;
        cnt = 0;
        repeat (8) begin
            #1 if (out_valid_o) cnt++;
            @(negedge clk_i);
        end
        chk("clear no output", cnt, 0);
`ifdef VFPU_MUL_STICKY_FLAGS_EN
        chk("clear sticky", sticky_flags_o, tb_sticky);
`endif

        // Reset while two vectors are in flight.
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        in_a_i = {NL{32'h3FC00000}}; in_b_i = {NL{32'h40000000}};
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0; rst_ni = 1'b0;
        #1 chk("midreset out_valid", out_valid_o, 0);
        chk("midreset out_res", out_res_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1; out_ready_i = 1'b1;
        #1 chk("midreset in_ready", in_ready_o, 1);
        cnt = 0;
        repeat (8) begin
            @(negedge clk_i);
            #1 if (out_valid_o) cnt++;
        end
        chk("midreset no output", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
